// File: rtl/ar_burst_splitter.sv
// Splits a byte-granular vector memory request into AXI INCR read bursts that
// never exceed MaxBurstLen beats and never cross a 4 KiB page.
module ar_burst_splitter #(
  parameter int AxiDataWidth = 512,
  parameter int AxiAddrWidth = 64,
  parameter int MaxBurstLen  = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [AxiAddrWidth-1:0] req_addr_i,
  input  logic [31:0]             req_bytes_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic                    ar_last_o,
  output logic                    busy_o
);

  localparam int B         = AxiDataWidth / 8;
  localparam int LgB       = $clog2(B);
  localparam int PageBeats = 4096 / B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [32:0]             rem_q, rem_d;
  logic [LgB-1:0]          off_q, off_d;
  logic [7:0]              len_q, len_d;
  logic                    last_q, last_d;

  logic                    load;
  logic [8:0]              beats_cur;
  logic [8:0]              beats_new;
  logic [33:0]             cons_cur;

  // Beats for a burst: enough to cover off+rem, capped by burst length and page end.
  function automatic logic [8:0] calc_beats(input logic [11-LgB:0] page_idx,
                                            input logic [32:0]      rem,
                                            input logic [LgB-1:0]   off);
    logic [33:0] need;
    logic [33:0] page;
    logic [33:0] beats;
    need  = ({1'b0, rem} + 34'(off) + 34'(B - 1)) >> LgB;
    page  = 34'(PageBeats) - 34'(page_idx);
    beats = need;
    if (34'(MaxBurstLen) < beats) beats = 34'(MaxBurstLen);
    if (page < beats) beats = page;
    return beats[8:0];
  endfunction

  // Request bytes actually covered by a burst, excluding the leading offset.
  function automatic logic [33:0] consumed(input logic [8:0]     beats,
                                           input logic [LgB-1:0] off);
    return (34'(beats) << LgB) - 34'(off);
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    off_d     = off_q;
    len_d     = len_q;
    last_d    = last_q;
    load      = 1'b0;
    beats_cur = {1'b0, len_q} + 9'd1;
    cons_cur  = consumed(beats_cur, off_q);

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_bytes_i != 32'd0) begin
            addr_d  = req_addr_i;
            rem_d   = {1'b0, req_bytes_i};
            off_d   = req_addr_i[LgB-1:0];
            load    = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = DROP;
          end
        end
      end
      ISSUE: begin
        if (ar_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            addr_d = {addr_q[AxiAddrWidth-1:LgB], {LgB{1'b0}}}
                     + (AxiAddrWidth'(beats_cur) << LgB);
            rem_d  = ({1'b0, rem_q} > cons_cur) ? 33'({1'b0, rem_q} - cons_cur) : 33'd0;
            off_d  = '0;
            load   = 1'b1;
          end
        end
      end
      DROP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The next burst's len/last are precomputed so every ar_* output comes from a flop.
    beats_new = calc_beats(addr_d[11:LgB], rem_d, off_d);
    if (load) begin
      len_d  = 8'(beats_new - 9'd1);
      last_d = consumed(beats_new, off_d) >= {1'b0, rem_d};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      off_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      off_q   <= off_d;
      len_q   <= len_d;
      last_q  <= last_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign ar_valid_o  = (state_q == ISSUE);
  assign busy_o      = (state_q != IDLE);
  assign ar_addr_o   = addr_q;
  assign ar_len_o    = len_q;
  assign ar_last_o   = last_q;
  assign ar_size_o   = 3'(LgB);
  assign ar_burst_o  = 2'b01;

endmodule

// File: tb/tb_ar_burst_splitter.sv
// Bench for ar_burst_splitter: directed corner cases plus random requests
// compared against a byte-range model of the expected burst sequence.
module tb_ar_burst_splitter;

  localparam int DW  = 64;
  localparam int AW  = 64;
  localparam int MBL = 256;
  localparam int B   = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_bytes_i;
  logic          ar_valid_o;
  logic          ar_ready_i;
  logic [AW-1:0] ar_addr_o;
  logic [7:0]    ar_len_o;
  logic [2:0]    ar_size_o;
  logic [1:0]    ar_burst_o;
  logic          ar_last_o;
  logic          busy_o;

  ar_burst_splitter #(
    .AxiDataWidth(DW),
    .AxiAddrWidth(AW),
    .MaxBurstLen (MBL)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_bytes_i(req_bytes_i),
    .ar_valid_o (ar_valid_o),
    .ar_ready_i (ar_ready_i),
    .ar_addr_o  (ar_addr_o),
    .ar_len_o   (ar_len_o),
    .ar_size_o  (ar_size_o),
    .ar_burst_o (ar_burst_o),
    .ar_last_o  (ar_last_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint unsigned addr;
    int              len;
    bit              last;
  } burst_t;

  burst_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Each burst covers whole beats from its aligned start up to the first of:
  // end of request, end of 4 KiB page, or MBL beats.
  function automatic void build(input longint unsigned a, input longint unsigned n);
    longint unsigned fin, al, page_end, lim, stop, beats;
    bit first;
    exp_q.delete();
    if (n == 0) return;
    fin   = a + n;
    al    = a - (a % B);
    first = 1'b1;
    forever begin
      page_end = (al / 4096) * 4096 + 4096;
      lim      = al + MBL * B;
      stop     = fin;
      if (page_end < stop) stop = page_end;
      if (lim < stop) stop = lim;
      beats = (stop - al + B - 1) / B;
      exp_q.push_back('{addr: first ? a : al, len: int'(beats) - 1,
                        last: (al + beats * B) >= fin});
      if ((al + beats * B) >= fin) break;
      al    = al + beats * B;
      first = 1'b0;
    end
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_req(input longint unsigned a, input int unsigned n, input int stall,
                         input bit rnd, input int abort_after);
    int  waits;
    bit  go;
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_bytes_i = n;
    ar_ready_i  = 1'b0;
    build(a, n);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_addr_i  = {$urandom, $urandom};
    req_bytes_i = $urandom;
    if (n == 0) begin
      check("drop_busy", 64'(busy_o), 64'd1);
      check("drop_ar_valid", 64'(ar_valid_o), 64'd0);
      check("drop_req_ready", 64'(req_ready_o), 64'd0);
      @(negedge clk_i);
      check("drop_done_req_ready", 64'(req_ready_o), 64'd1);
      check("drop_done_ar_valid", 64'(ar_valid_o), 64'd0);
      $display("req addr=0x%0h bytes=%0d -> no AR", a, n);
      return;
    end
    foreach (exp_q[i]) begin
      waits = 0;
      forever begin
        check($sformatf("b%0d_valid", i), 64'(ar_valid_o), 64'd1);
        check($sformatf("b%0d_addr", i), ar_addr_o, exp_q[i].addr);
        check($sformatf("b%0d_len", i), 64'(ar_len_o), 64'(exp_q[i].len));
        check($sformatf("b%0d_last", i), 64'(ar_last_o), 64'(exp_q[i].last));
        check($sformatf("b%0d_req_ready", i), 64'(req_ready_o), 64'd0);
        go = (waits >= stall) && (!rnd || waits >= stall + 8 || $urandom_range(0, 2) != 0);
        ar_ready_i = go;
        @(negedge clk_i);
        waits++;
        if (go) break;
      end
      ar_ready_i = 1'b0;
      if (i == abort_after) begin
        $display("req addr=0x%0h bytes=%0d aborted after %0d bursts", a, n, i + 1);
        return;
      end
    end
    check("post_ar_valid", 64'(ar_valid_o), 64'd0);
    check("post_busy", 64'(busy_o), 64'd0);
    check("post_req_ready", 64'(req_ready_o), 64'd1);
    $display("req addr=0x%0h bytes=%0d -> %0d bursts", a, n, exp_q.size());
  endtask

  initial begin
    longint unsigned a;
    int unsigned     n;
    int              sel;

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_bytes_i = '0;
    ar_ready_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ar_valid", 64'(ar_valid_o), 64'd0);
    check("rst_ar_last", 64'(ar_last_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ar_addr", ar_addr_o, 64'd0);
    check("rst_ar_len", 64'(ar_len_o), 64'd0);
    check("ar_size", 64'(ar_size_o), 64'd3);
    check("ar_burst", 64'(ar_burst_o), 64'd1);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_req(64'h1000, 16, 0, 1'b0, -1);
    run_req(64'h1004, 16, 0, 1'b0, -1);
    run_req(64'h1FF8, 32, 0, 1'b0, -1);
    run_req(64'h0, 2056, 0, 1'b0, -1);
    run_req(64'h1FF8, 32, 5, 1'b0, -1);
    run_req(64'h2345, 0, 0, 1'b0, -1);
    check("const_size", 64'(ar_size_o), 64'd3);
    check("const_burst", 64'(ar_burst_o), 64'd1);

    // Reset between the first and second burst must cancel the remainder.
    run_req(64'h0, 2056, 0, 1'b0, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_ar_valid", 64'(ar_valid_o), 64'd0);
    check("midrst_ar_last", 64'(ar_last_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_ar_addr", ar_addr_o, 64'd0);
    check("midrst_ar_len", 64'(ar_len_o), 64'd0);
    check("midrst_req_ready", 64'(req_ready_o), 64'd1);
    ar_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("midrst_no_ar", 64'(ar_valid_o), 64'd0);
    end
    ar_ready_i = 1'b0;
    run_req(64'h1004, 16, 0, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      a = {28'd0, 4'($urandom_range(0, 15)), $urandom};
      if (k % 4 == 0) a = (a & ~64'hFFF) | 64'(4096 - $urandom_range(1, 64));
      sel = $urandom_range(0, 9);
      if (sel == 0)      n = 0;
      else if (sel <= 5) n = $urandom_range(1, 100);
      else if (sel <= 8) n = $urandom_range(1, 6000);
      else               n = $urandom_range(1, 40000);
      run_req(a, n, 0, 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
